lc3_execute_mc: RTL
===================

Name: lc3_execute_mc

Overview:
Parametrised, multi-cycle successor to the LC3 execute stage. It sits between decode/register-read and the memory/writeback stages.
- Keeps the existing ADD/AND/NOT, address-generation and bypass behaviour.
- Generalises the datapath width.
- Adds shift operations and an iterative multiplier, with a busy/stall handshake to decode.

Parameters:
DW, 16, datapath width (operands, aluout, pcout, M_Data); must be >= 16.
SHW, $clog2(DW), shift-amount width taken from aluin2 LSBs.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
enable_execute  in  1  issue valid; instruction accepted on a cycle with enable_execute=1 and busy=0
E_Control  in  7  [6:4] alu_op, [3:2] pcselect1, [1] pcselect2, [0] op2select
IR  in  16  instruction
npc  in  DW  next PC of instruction
VSR1, VSR2  in  DW  register-file read values
Mem_Bypass_Val  in  DW  forwarded memory-stage value
bypass_alu_1, bypass_alu_2  in  1  select registered aluout for operand 1/2
bypass_mem_1, bypass_mem_2  in  1  select Mem_Bypass_Val for operand 1/2
W_Control_in  in  2  writeback control, pipelined
Mem_Control_in  in  1  memory control, pipelined
busy  out  1  multiplier in progress; decode must hold inputs and stall
aluout  out  DW  registered ALU result
pcout  out  DW  registered address result
NZP  out  3  registered sign flags of the ALU result
IR_Exec  out  16  registered IR
W_Control_out  out  2  registered
Mem_Control_out  out  1  registered
sr1, sr2  out  3  combinational IR[8:6], IR[2:0] to register file
dr  out  3  registered IR[11:9]
M_Data  out  DW  registered store data (operand 2 after bypass)

Behaviour:
- Reset (synchronous, active-high):
  - All registered outputs = 0 and NZP = 3'b000; busy = 0.
  - Any multiply in progress is aborted; reset overrides enable_execute.
- Operand select:
  - op1 priority: bypass_alu_1 → aluout; else bypass_mem_1 → Mem_Bypass_Val; else VSR1.
  - op2 priority: the same with the _2 signals, over VSR2.
  - aluin2 = op2select ? op2 : sext(IR[4:0]).
  - M_Data captures op2.
- Sign extension: sext(IR[10:0]), sext(IR[8:0]), sext(IR[5:0]), sext(IR[4:0]), each to DW.
- Address generation:
  - pcselect1: 0 → offset11, 1 → offset9, 2 → offset6, 3 → 0.
  - base = pcselect2 ? npc : op1.
  - pcout = base + offset, modulo 2^DW.
- alu_op:
  - 0 ADD: op1+aluin2, modulo 2^DW, carry dropped.
  - 1 AND.
  - 2 NOT op1.
  - 3 PASS aluin2.
  - 4 MUL: low DW bits of op1*aluin2.
  - 5 SHL, 6 SHR (logical), 7 SRA: op1 shifted by aluin2[SHW-1:0].
- Single-cycle ops (alu_op != 4):
  - Accepted when enable_execute=1 and busy=0.
  - All outputs update on that edge, so latency = 1.
- Outputs hold their values whenever no instruction completes, including enable_execute=0.
- NZP: {aluout[DW-1], aluout==0, !aluout[DW-1] && aluout!=0}, updated together with aluout.
- Multiply state machine, states IDLE, MUL:
  - IDLE→MUL on accept with alu_op=4: operands, IR, npc and controls are latched; busy=1 from the next cycle.
  - MUL runs DW cycles of shift-add, then returns to IDLE. On the return edge all outputs update together and busy falls.
  - Total latency from accept to result is DW+1 edges.
- While busy: enable_execute, bypass inputs and operand inputs are ignored. Only the latched copies are used, so a bypass changing mid-multiply has no effect.
- Back-to-back issue: a new instruction can be accepted on the first cycle busy=0.
- Reset during MUL → IDLE immediately; no result is written and outputs are cleared.

Decomposition:
- Package lc3_exe_pkg holds:
  - alu_op localparams (ALU_ADD..ALU_SRA);
  - pcselect1 encodings;
  - E_Control field-position constants;
  - exe_state_t enum (IDLE, MUL).
- Sub-module lc3_exe_mul_iter (parameter DW): start/operands in, busy/done/product out; a shift-add engine with a cycle counter.
- Everything else stays flat in lc3_execute_mc.

Test Plan:
- ADD imm: VSR1=16'h0005, IR[4:0]=5'b11101 (-3), op2select=0, alu_op=0 → aluout=16'h0002, NZP=3'b001 after 1 clock.
- Bypass priority: bypass_alu_1=1 and bypass_mem_1=1, prior aluout=16'h1234, Mem_Bypass_Val=16'hFFFF, NOT → aluout=16'hEDCB, NZP=3'b100.
- Address: pcselect2=1, npc=16'h3001, pcselect1=1, IR[8:0]=9'h1FF → pcout=16'h3000.
- MUL: op1=16'h0007, op2=16'h0009, DW=16 → busy high 16 cycles, then aluout=16'h003F. A changing bypass during busy has no effect; the next ADD is accepted on the first busy=0 cycle.
- Shifts: op1=16'h8000, amount 3 → SHR gives 16'h1000, SRA gives 16'hF000, SHL by 1 gives 16'h0000 with NZP=3'b010.
- Reset at MUL cycle 5 → next edge busy=0, aluout=0, NZP=0. A following ADD completes normally; repeat the MUL test with DW=32.

Source files
------------

// File: rtl/lc3_exe_pkg.sv
// lc3_exe_pkg: shared encodings for the multi-cycle LC3 execute stage
package lc3_exe_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_NOT = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;
    localparam logic [2:0] ALU_MUL = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SHR = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;
    localparam logic [1:0] PC_OFF11 = 2'd0;
    localparam logic [1:0] PC_OFF9 = 2'd1;
    localparam logic [1:0] PC_OFF6 = 2'd2;
    localparam logic [1:0] PC_ZERO = 2'd3;
    localparam int EC_ALU_HI = 6;
    localparam int EC_ALU_LO = 4;
    localparam int EC_PC1_HI = 3;
    localparam int EC_PC1_LO = 2;
    localparam int EC_PC2 = 1;
    localparam int EC_OP2 = 0;
    typedef enum logic {IDLE, MUL} exe_state_t;
endpackage

// File: rtl/lc3_execute_mc_if.sv
// lc3_execute_mc_if: decode-to-execute bundle; master is the decode side, slave the execute stage
interface lc3_execute_mc_if #(parameter int DW = 16);
    logic enable_execute;
    logic [6:0] E_Control;
    logic [15:0] IR;
    logic [DW-1:0] npc, VSR1, VSR2, Mem_Bypass_Val;
    logic bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0] W_Control_in;
    logic Mem_Control_in;
    logic busy;
    logic [DW-1:0] aluout, pcout, M_Data;
    logic [2:0] NZP, sr1, sr2, dr;
    logic [15:0] IR_Exec;
    logic [1:0] W_Control_out;
    logic Mem_Control_out;
    modport master (
        output enable_execute, E_Control, IR, npc, VSR1, VSR2, Mem_Bypass_Val,
               bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, W_Control_in, Mem_Control_in,
        input busy, aluout, pcout, NZP, IR_Exec, W_Control_out, Mem_Control_out, sr1, sr2, dr, M_Data
    );
    modport slave (
        input enable_execute, E_Control, IR, npc, VSR1, VSR2, Mem_Bypass_Val,
              bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, W_Control_in, Mem_Control_in,
        output busy, aluout, pcout, NZP, IR_Exec, W_Control_out, Mem_Control_out, sr1, sr2, dr, M_Data
    );
endinterface

// File: rtl/lc3_exe_mul_iter.sv
// lc3_exe_mul_iter: shift-add multiplier, one multiplier bit per cycle, DW cycles per product
module lc3_exe_mul_iter #(parameter int DW = 16) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    output logic busy,
    output logic done,
    output logic [DW-1:0] product
);
    localparam int CW = $clog2(DW + 1);
    logic [DW-1:0] mcand, mplier, acc;
    logic [CW-1:0] cnt;
    // product already includes the current step so the result is usable on the final edge
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done = busy && cnt == CW'(DW - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            cnt <= '0;
            acc <= '0;
            mcand <= a;
            mplier <= b;
        end else if (busy) begin
            acc <= product;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/lc3_execute_mc.sv
// lc3_execute_mc: parametrised LC3 execute stage with shifts and an iterative multiplier
import lc3_exe_pkg::*;
module lc3_execute_mc #(
    parameter int DW = 16,
    parameter int SHW = $clog2(DW)
) (
    input logic clock,
    input logic reset,
    lc3_execute_mc_if.slave bus
);
    exe_state_t state;
    logic [2:0] alu_op;
    logic [1:0] pcsel1;
    logic pcsel2, op2sel, accept, mul_start, mul_busy, mul_done, mul_commit, commit;
    logic [DW-1:0] op1, op2, aluin2, offset, base, addr, result, product;
    logic [DW-1:0] pc_l, md_l, c_alu, c_pc, c_md;
    logic [15:0] ir_l, c_ir;
    logic [1:0] w_l, c_w;
    logic m_l, c_m;
    function automatic logic [2:0] nzp_of(input logic [DW-1:0] v);
        return {v[DW-1], v == '0, !v[DW-1] && v != '0};
    endfunction
    assign alu_op = bus.E_Control[EC_ALU_HI:EC_ALU_LO];
    assign pcsel1 = bus.E_Control[EC_PC1_HI:EC_PC1_LO];
    assign pcsel2 = bus.E_Control[EC_PC2];
    assign op2sel = bus.E_Control[EC_OP2];
    assign bus.sr1 = bus.IR[8:6];
    assign bus.sr2 = bus.IR[2:0];
    assign bus.busy = state == MUL;
    assign accept = bus.enable_execute && state == IDLE;
    assign mul_start = accept && alu_op == ALU_MUL;
    assign op1 = bus.bypass_alu_1 ? bus.aluout : bus.bypass_mem_1 ? bus.Mem_Bypass_Val : bus.VSR1;
    assign op2 = bus.bypass_alu_2 ? bus.aluout : bus.bypass_mem_2 ? bus.Mem_Bypass_Val : bus.VSR2;
    assign aluin2 = op2sel ? op2 : {{(DW-5){bus.IR[4]}}, bus.IR[4:0]};
    assign offset = pcsel1 == PC_OFF11 ? {{(DW-11){bus.IR[10]}}, bus.IR[10:0]} :
                    pcsel1 == PC_OFF9 ? {{(DW-9){bus.IR[8]}}, bus.IR[8:0]} :
                    pcsel1 == PC_OFF6 ? {{(DW-6){bus.IR[5]}}, bus.IR[5:0]} : '0;
    assign base = pcsel2 ? bus.npc : op1;
    assign addr = base + offset;
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD: result = op1 + aluin2;
            ALU_AND: result = op1 & aluin2;
            ALU_NOT: result = ~op1;
            ALU_PASS: result = aluin2;
            ALU_SHL: result = op1 << aluin2[SHW-1:0];
            ALU_SHR: result = op1 >> aluin2[SHW-1:0];
            ALU_SRA: result = $signed(op1) >>> aluin2[SHW-1:0];
            default: result = '0;
        endcase
    end
    lc3_exe_mul_iter #(.DW(DW)) mul (
        .clk(clock),
        .rst(reset),
        .start(mul_start),
        .a(op1),
        .b(aluin2),
        .busy(mul_busy),
        .done(mul_done),
        .product(product)
    );
    // a multiply commits from its latched copies; everything else commits straight from the inputs
    assign mul_commit = state == MUL && mul_busy && mul_done;
    assign commit = (accept && alu_op != ALU_MUL) || mul_commit;
    assign c_alu = mul_commit ? product : result;
    assign c_pc = mul_commit ? pc_l : addr;
    assign c_md = mul_commit ? md_l : op2;
    assign c_ir = mul_commit ? ir_l : bus.IR;
    assign c_w = mul_commit ? w_l : bus.W_Control_in;
    assign c_m = mul_commit ? m_l : bus.Mem_Control_in;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc_l <= '0;
            md_l <= '0;
            ir_l <= '0;
            w_l <= '0;
            m_l <= 1'b0;
            bus.aluout <= '0;
            bus.pcout <= '0;
            bus.M_Data <= '0;
            bus.NZP <= 3'b000;
            bus.IR_Exec <= '0;
            bus.dr <= '0;
            bus.W_Control_out <= '0;
            bus.Mem_Control_out <= 1'b0;
        end else begin
            if (mul_start) begin
                state <= MUL;
                pc_l <= addr;
                md_l <= op2;
                ir_l <= bus.IR;
                w_l <= bus.W_Control_in;
                m_l <= bus.Mem_Control_in;
            end else if (mul_commit) begin
                state <= IDLE;
            end
            if (commit) begin
                bus.aluout <= c_alu;
                bus.pcout <= c_pc;
                bus.M_Data <= c_md;
                bus.NZP <= nzp_of(c_alu);
                bus.IR_Exec <= c_ir;
                bus.dr <= c_ir[11:9];
                bus.W_Control_out <= c_w;
                bus.Mem_Control_out <= c_m;
            end
        end
    end
endmodule
